// File: rtl/Common.sv
// Shared activation-function encoding used by the activation pipeline and its bench.
package Common;

    // Encodings 4..7 are not named; the datapath treats them as identity.
    typedef enum logic [2:0] {
        ACT_STEP    = 3'd0,
        ACT_SIGMOID = 3'd1,
        ACT_TANH    = 3'd2,
        ACT_RELU    = 3'd3
    } act_func;

endpackage

// File: rtl/FixedPoint.sv
// Fixed-point constants for the piecewise-linear sigmoid, plus a saturation helper.
package FixedPoint;

    typedef enum logic [1:0] {
        SEG_0   = 2'd0,   // [0, 1)
        SEG_1   = 2'd1,   // [1, 2.375)
        SEG_2   = 2'd2,   // [2.375, 5)
        SEG_SAT = 2'd3    // >= 5
    } seg_e;

    function automatic longint fx_one(input int frac);
        return longint'(1) <<< frac;
    endfunction

    function automatic longint sig_bp_1(input int frac);
        return longint'(1) <<< frac;
    endfunction

    function automatic longint sig_bp_2(input int frac);
        return (longint'(19) <<< frac) >>> 3;
    endfunction

    function automatic longint sig_bp_sat(input int frac);
        return longint'(5) <<< frac;
    endfunction

    // Offsets are exact fractions of 2**frac, truncated toward zero.
    function automatic longint sig_off_0(input int frac);
        return (longint'(1) <<< frac) >>> 1;
    endfunction

    function automatic longint sig_off_1(input int frac);
        return (longint'(5) <<< frac) >>> 3;
    endfunction

    function automatic longint sig_off_2(input int frac);
        return (longint'(27) <<< frac) >>> 5;
    endfunction

    function automatic longint saturate(input longint v, input int width);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -(longint'(1) <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/act_lane.sv
// One activation lane: stage 1 folds sign and picks a segment, stage 2 evaluates and saturates.
// With ACT_SAT_STATS_EN defined the lane also reports whether its beat saturated.
module act_lane
    import Common::*;
    import FixedPoint::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1_en_i,
    input  logic             s2_en_i,
    input  act_func          act_s1_i,
    input  act_func          act_s2_i,
    input  logic [WIDTH-1:0] sum_i,
`ifdef ACT_SAT_STATS_EN
    output logic             sat_o,
`endif
    output logic [WIDTH-1:0] pred_o
);

    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam longint ZERO = 64'sd0;

    logic [WIDTH:0]   dbl;
    logic             dbl_ovf;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] ax_d;
    logic             neg_d;
    seg_e             seg_d;
    longint           ax_l1;

    logic [WIDTH-1:0] s1_x_q;
    logic [WIDTH-1:0] s1_ax_q;
    logic             s1_neg_q;
    seg_e             s1_seg_q;
    logic [WIDTH-1:0] s2_pred_q;
    logic [WIDTH-1:0] pred_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        dbl     = {sum_i, 1'b0};
        dbl_ovf = dbl[WIDTH] != dbl[WIDTH-1];
        ev      = sum_i;
        if (act_s1_i == ACT_TANH) begin
            ev = dbl_ovf ? (dbl[WIDTH] ? MIN_W : MAX_W) : dbl[WIDTH-1:0];
        end
        neg_d = ev[WIDTH-1];
        ax_d  = ev;
        if (ev == MIN_W) begin
            ax_d = MAX_W;
        end else if (neg_d) begin
            ax_d = -ev;
        end
        ax_l1 = {{(64-WIDTH){1'b0}}, ax_d};
        seg_d = SEG_0;
        if (ax_l1 >= sig_bp_sat(FRAC))    seg_d = SEG_SAT;
        else if (ax_l1 >= sig_bp_2(FRAC)) seg_d = SEG_2;
        else if (ax_l1 >= sig_bp_1(FRAC)) seg_d = SEG_1;
    end

    longint ax_l;
    longint x_l;
    longint one_l;
    longint f_l;
    longint sig_l;
    longint res_l;

    always_comb begin
        ax_l  = {{(64-WIDTH){1'b0}}, s1_ax_q};
        x_l   = {{(64-WIDTH){s1_x_q[WIDTH-1]}}, s1_x_q};
        one_l = fx_one(FRAC);
        case (s1_seg_q)
            SEG_0:   f_l = (ax_l >>> 2) + sig_off_0(FRAC);
            SEG_1:   f_l = (ax_l >>> 3) + sig_off_1(FRAC);
            SEG_2:   f_l = (ax_l >>> 5) + sig_off_2(FRAC);
            default: f_l = one_l;
        endcase
        sig_l = s1_neg_q ? (one_l - f_l) : f_l;
        case (act_s2_i)
            ACT_STEP:    res_l = (!s1_neg_q && (ax_l != ZERO)) ? one_l : ZERO;
            ACT_RELU:    res_l = s1_neg_q ? ZERO : x_l;
            ACT_SIGMOID: res_l = sig_l;
            ACT_TANH:    res_l = (sig_l <<< 1) - one_l;
            default:     res_l = x_l;
        endcase
        pred_d = WIDTH'(saturate(res_l, WIDTH));
    end

    // NOTE: sequential state uses non-blocking assignments only, so stage 2 sees last cycle's stage 1.
    // NOTE: datapath registers are reset too, so out_pred reads zero during and after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x_q    <= '0;
            s1_ax_q   <= '0;
            s1_neg_q  <= 1'b0;
            s1_seg_q  <= SEG_0;
            s2_pred_q <= '0;
        end else begin
            if (s1_en_i) begin
                s1_x_q   <= sum_i;
                s1_ax_q  <= ax_d;
                s1_neg_q <= neg_d;
                s1_seg_q <= seg_d;
            end
            if (s2_en_i) begin
                s2_pred_q <= pred_d;
            end
        end
    end

    assign pred_o = s2_pred_q;

`ifdef ACT_SAT_STATS_EN
    logic sat1_d;
    logic sat2_d;
    logic s1_sat_q;
    logic s2_sat_q;

    // Only sigmoid/tanh consume |x|, so abs clamping counts only for them.
    always_comb begin
        sat1_d = ((act_s1_i == ACT_TANH) && dbl_ovf) ||
                 (((act_s1_i == ACT_TANH) || (act_s1_i == ACT_SIGMOID)) && (ev == MIN_W));
        sat2_d = s1_sat_q || (saturate(res_l, WIDTH) != res_l);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sat_q <= 1'b0;
            s2_sat_q <= 1'b0;
        end else begin
            if (s1_en_i) s1_sat_q <= sat1_d;
            if (s2_en_i) s2_sat_q <= sat2_d;
        end
    end

    assign sat_o = s2_sat_q;
`endif

endmodule

// File: rtl/activation_pipe.sv
// Two-stage, LANES-wide activation pipeline with valid/ready handshake on both sides.
// Defining ACT_SAT_STATS_EN adds the sat_count port counting consumed beats that saturated.
module activation_pipe
    import Common::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  act_func                      in_act,
    input  logic [LANES-1:0][WIDTH-1:0]  in_sum,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef ACT_SAT_STATS_EN
    output logic [15:0]                  sat_count,
`endif
    output logic [LANES-1:0][WIDTH-1:0]  out_pred
);

    logic    s1_valid_q;
    logic    s1_valid_d;
    logic    s2_valid_q;
    logic    s2_valid_d;
    act_func s1_act_q;
    logic    accept;
    logic    s2_en;
    logic    pop;

    // Stage 1 may load whenever it is empty or will drain into stage 2 this cycle.
    assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign s2_en     = s1_valid_q && (!s2_valid_q || out_ready);
    assign pop       = s2_valid_q && out_ready;
    assign out_valid = s2_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept)     s1_valid_d = 1'b1;
        else if (s2_en) s1_valid_d = 1'b0;
        s2_valid_d = s2_valid_q;
        if (s2_en)      s2_valid_d = 1'b1;
        else if (pop)   s2_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_act_q   <= ACT_STEP;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) s1_act_q <= in_act;
        end
    end

`ifdef ACT_SAT_STATS_EN
    logic [LANES-1:0] lane_sat;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .s1_en_i  (accept),
            .s2_en_i  (s2_en),
            .act_s1_i (in_act),
            .act_s2_i (s1_act_q),
            .sum_i    (in_sum[g]),
`ifdef ACT_SAT_STATS_EN
            .sat_o    (lane_sat[g]),
`endif
            .pred_o   (out_pred[g])
        );
    end

`ifdef ACT_SAT_STATS_EN
    logic [15:0] sat_count_q;
    logic [15:0] sat_count_d;

    always_comb begin
        sat_count_d = sat_count_q;
        if (pop && (|lane_sat) && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_count_q <= 16'd0;
        else        sat_count_q <= sat_count_d;
    end

    assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe (WIDTH=16, FRAC=8, LANES=4); sat_count checks follow ACT_SAT_STATS_EN.
module tb_activation_pipe;
    import Common::*;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int LANES = 4;

    typedef logic [LANES-1:0][WIDTH-1:0] beat_t;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    in_valid;
    logic    in_ready;
    act_func in_act;
    beat_t   in_sum;
    logic    out_valid;
    logic    out_ready;
    beat_t   out_pred;
`ifdef ACT_SAT_STATS_EN
    logic [15:0] sat_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    activation_pipe #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ACT_SAT_STATS_EN
        .sat_count (sat_count),
`endif
        .out_pred  (out_pred)
    );

    function automatic beat_t mk_beat(input int i);
        beat_t b;
        for (int j = 0; j < LANES; j++) b[j] = WIDTH'(256 * (i + 1) + 17 * j);
        return b;
    endfunction

    // Called at a negedge; returns at the negedge where the result should be visible.
    task automatic issue_beat(input act_func act, input beat_t sum, output logic valid_early);
        in_valid  = 1'b1;
        in_act    = act;
        in_sum    = sum;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        in_sum      = '0;
        valid_early = out_valid;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_act    = ACT_STEP;
        in_sum    = '0;
        out_ready = 1'b0;
        #3;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if (out_pred !== '0) begin
            miscompares++;
            $display("FAIL reset_out_pred: got %h expected 0", out_pred);
        end
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
`ifdef ACT_SAT_STATS_EN
        vectors++;
        if (sat_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_sat_count: got %0d expected 0", sat_count);
        end
`endif
    endtask

    task automatic test_sigmoid();
        beat_t exp;
        logic  early;
        issue_beat(ACT_SIGMOID, {16'h0500, 16'hFF00, 16'h0100, 16'h0000}, early);
        exp = {16'h0100, 16'h0040, 16'h00C0, 16'h0080};
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL sigmoid_latency_early: out_valid=%b after 1 cycle, expected 0", early);
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL sigmoid_latency: out_valid=%b after 2 cycles, expected 1", out_valid);
        end
        for (int i = 0; i < LANES; i++) begin
            vectors++;
            if (out_pred[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL sigmoid_lane%0d: got %h expected %h", i, out_pred[i], exp[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_tanh();
        beat_t exp;
        logic  early;
        issue_beat(ACT_TANH, {16'h0080, 16'h8000, 16'h7FFF, 16'h0000}, early);
        exp = {16'h0080, 16'hFF00, 16'h0100, 16'h0000};
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL tanh_valid: got %b expected 1", out_valid);
        end
        for (int i = 0; i < LANES; i++) begin
            vectors++;
            if (out_pred[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL tanh_lane%0d: got %h expected %h", i, out_pred[i], exp[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
`ifdef ACT_SAT_STATS_EN
        vectors++;
        if (sat_count !== 16'd1) begin
            miscompares++;
            $display("FAIL tanh_sat_count: got %0d expected 1", sat_count);
        end
`endif
    endtask

    task automatic test_step_relu_ident();
        beat_t   exp;
        beat_t   sum;
        logic    early;
        act_func unk;
        issue_beat(ACT_STEP, {16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000}, early);
        exp = {16'h0100, 16'h0000, 16'h0100, 16'h0000};
        for (int i = 0; i < LANES; i++) begin
            vectors++;
            if (out_pred[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL step_lane%0d: got %h expected %h", i, out_pred[i], exp[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        issue_beat(ACT_RELU, {16'h7FFF, 16'h8000, 16'h0300, 16'hFD00}, early);
        exp = {16'h7FFF, 16'h0000, 16'h0300, 16'h0000};
        for (int i = 0; i < LANES; i++) begin
            vectors++;
            if (out_pred[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL relu_lane%0d: got %h expected %h", i, out_pred[i], exp[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        unk = act_func'(3'd7);
        sum = {16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
        issue_beat(unk, sum, early);
        exp = {16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
        for (int i = 0; i < LANES; i++) begin
            vectors++;
            if (out_pred[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL ident_lane%0d: got %h expected %h", i, out_pred[i], exp[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
`ifdef ACT_SAT_STATS_EN
        vectors++;
        if (sat_count !== 16'd1) begin
            miscompares++;
            $display("FAIL nonsat_sat_count: got %0d expected 1", sat_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int    sent = 0;
        int    recv = 0;
        int    inflight;
        logic  exp_ready;
        logic  prev_stall = 1'b0;
        beat_t prev_pred  = '0;
        beat_t exp;
        int    extra = 0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            in_act    = ACT_RELU;
            in_sum    = mk_beat(sent);
            #1;
            inflight  = sent - recv;
            exp_ready = (inflight < 2) || out_ready;
            vectors++;
            if (in_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", c, in_ready, exp_ready);
            end
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pred !== prev_pred) begin
                    miscompares++;
                    $display("FAIL b2b_hold cycle %0d: got valid=%b pred=%h expected valid=1 pred=%h",
                             c, out_valid, out_pred, prev_pred);
                end
            end
            if (out_valid && out_ready) begin
                exp = mk_beat(recv);
                vectors++;
                if (out_pred !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_data beat %0d: got %h expected %h", recv, out_pred, exp);
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pred  = out_pred;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (recv != 8) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d beats expected 8", recv);
        end
        for (int c = 0; c < 4; c++) begin
            if (out_valid) extra++;
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL b2b_duplicate: got %0d extra valid cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_midflight();
        beat_t exp;
        logic  early;
        int    stale = 0;
        in_valid  = 1'b1;
        in_act    = ACT_SIGMOID;
        in_sum    = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_sum = {16'h0500, 16'h0500, 16'h0500, 16'h0500};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_full: got valid=%b ready=%b expected valid=1 ready=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pred !== '0) begin
            miscompares++;
            $display("FAIL midflight_reset: got valid=%b ready=%b pred=%h expected 0/1/0",
                     out_valid, in_ready, out_pred);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stale++;
        end
        vectors++;
        if (stale != 0) begin
            miscompares++;
            $display("FAIL midflight_stale: got %0d valid cycles expected 0", stale);
        end
`ifdef ACT_SAT_STATS_EN
        vectors++;
        if (sat_count !== 16'd0) begin
            miscompares++;
            $display("FAIL midflight_sat_count: got %0d expected 0", sat_count);
        end
`endif
        issue_beat(ACT_RELU, {16'h0040, 16'hFFFF, 16'h0300, 16'h0001}, early);
        exp = {16'h0040, 16'h0000, 16'h0300, 16'h0001};
        vectors++;
        if (early !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midflight_latency: got early=%b late=%b expected 0 then 1", early, out_valid);
        end
        vectors++;
        if (out_pred !== exp) begin
            miscompares++;
            $display("FAIL midflight_data: got %h expected %h", out_pred, exp);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sigmoid();
        test_tanh();
        test_step_relu_ident();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1);
    end

endmodule
